// File: rtl/run_sequencer.sv
// run_sequencer: queues CPU start addresses, launches one run at a time,
// measures each run in WAIT cycles (with timeout) and reports the result.
module run_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 30000
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic                     req_valid_i,
  input  logic [7:0]               req_addr_i,
  output logic                     req_ready_o,
  input  logic                     flush_i,
  output logic                     cpu_start_o,
  output logic [7:0]               cpu_start_addr_o,
  input  logic                     cpu_done_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [7:0]               result_addr_o,
  output logic [14:0]              result_cycles_o,
  output logic                     result_timeout_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   queue_count_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
  localparam logic [14:0] TO_VAL   = 15'(TIMEOUT);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_LAUNCH = 2'd1;
  localparam logic [1:0]  S_WAIT   = 2'd2;
  localparam logic [1:0]  S_REPORT = 2'd3;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic [1:0]    r_state;
  logic [7:0]    r_run_addr;
  logic [14:0]   r_cnt;
  logic          r_timeout;
  logic          r_start;

  logic          w_push;
  logic          w_pop;
  logic [14:0]   w_cnt_nxt;
  logic          w_done_ok;
  logic          w_hit_to;

  // Ready depends only on occupancy, so a full queue never bypasses to a pop.
  assign req_ready_o = (r_count != FULL);
  assign w_push      = req_valid_i && req_ready_o && !flush_i;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0) && !flush_i;

  // r_cnt is 0 during the first WAIT cycle, which masks a stale done.
  assign w_cnt_nxt   = r_cnt + 15'd1;
  assign w_done_ok   = cpu_done_i && (r_cnt != 15'd0);
  assign w_hit_to    = (w_cnt_nxt == TO_VAL);

  // Queue storage; contents need no reset since count gates every read.
  always_ff @(posedge clock_i) begin
    if (w_push) r_mem[r_wptr] <= req_addr_i;
  end

  // Queue pointers and occupancy; flush wins over any push that cycle.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Run FSM: pop -> one-cycle start -> count WAIT cycles -> hold result.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_state    <= S_IDLE;
      r_run_addr <= 8'd0;
      r_cnt      <= 15'd0;
      r_timeout  <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_run_addr <= r_mem[r_rptr];
            r_start    <= 1'b1;
            r_state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_cnt     <= 15'd0;
          r_timeout <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= w_cnt_nxt;
          if (w_done_ok) begin
            r_timeout <= 1'b0;
            r_state   <= S_REPORT;
          end else if (w_hit_to) begin
            r_timeout <= 1'b1;
            r_state   <= S_REPORT;
          end
        end
        default: begin
          if (result_ready_i) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_start_o      = r_start;
  assign cpu_start_addr_o = r_start ? r_run_addr : 8'd0;
  assign result_valid_o   = (r_state == S_REPORT);
  assign result_addr_o    = result_valid_o ? r_run_addr : 8'd0;
  assign result_cycles_o  = result_valid_o ? r_cnt : 15'd0;
  assign result_timeout_o = result_valid_o && r_timeout;
  assign busy_o           = (r_state != S_IDLE);
  assign queue_count_o    = r_count;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: stimulus pushes expected launches and
// results into queues; a negedge monitor pops and compares them.
module tb_run_sequencer;

  typedef struct {
    logic [7:0]  a;
    logic [14:0] c;
    logic        t;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [7:0]  req_addr;
  logic        req_ready_o;
  logic        flush;
  logic        cpu_start_o;
  logic [7:0]  cpu_start_addr_o;
  logic        cpu_done;
  logic        result_valid_o;
  logic        result_ready;
  logic [7:0]  result_addr_o;
  logic [14:0] result_cycles_o;
  logic        result_timeout_o;
  logic        busy_o;
  logic [2:0]  queue_count_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_launch[$];
  res_t       exp_res[$];
  logic       prev_start = 1'b0;
  logic [7:0] mon_a;
  res_t       mon_r;

  always #5 clk = ~clk;

  run_sequencer #(.DEPTH(4), .TIMEOUT(10)) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready_o),
    .flush_i(flush),
    .cpu_start_o(cpu_start_o), .cpu_start_addr_o(cpu_start_addr_o),
    .cpu_done_i(cpu_done),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready),
    .result_addr_o(result_addr_o), .result_cycles_o(result_cycles_o),
    .result_timeout_o(result_timeout_o),
    .busy_o(busy_o), .queue_count_o(queue_count_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every start pulse and every accepted result is checked
  // against the head of its expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_start_o) begin
        chk("start_pulse_width", {31'd0, prev_start}, 32'd0);
        if (exp_launch.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_launch actual=%0d required=none", cpu_start_addr_o);
        end else begin
          mon_a = exp_launch.pop_front();
          chk("launch_addr", {24'd0, cpu_start_addr_o}, {24'd0, mon_a});
        end
      end
      if (result_valid_o && result_ready) begin
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result actual=%0d required=none", result_addr_o);
        end else begin
          mon_r = exp_res.pop_front();
          chk("result_addr",    {24'd0, result_addr_o},    {24'd0, mon_r.a});
          chk("result_cycles",  {17'd0, result_cycles_o},  {17'd0, mon_r.c});
          chk("result_timeout", {31'd0, result_timeout_o}, {31'd0, mon_r.t});
        end
      end
    end
    prev_start = cpu_start_o;
  end

  task automatic push(input logic [7:0] a, input bit exp);
    if (exp) exp_launch.push_back(a);
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic exp_result(input logic [7:0] a, input int c, input bit t);
    res_t r;
    r.a = a; r.c = 15'(c); r.t = t;
    exp_res.push_back(r);
  endtask

  task automatic wait_start();
    int n = 0;
    do begin @(negedge clk); n++; end while (!cpu_start_o && n < 60);
    if (!cpu_start_o) begin
      checks++; errors++;
      $display("FAIL wait_start actual=timeout required=start_pulse");
    end
  endtask

  // Raise done during the Nth WAIT cycle of the next launched run.
  task automatic run_done(input int n);
    wait_start();
    @(posedge clk); #1;
    repeat (n - 1) @(posedge clk);
    #1 cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((busy_o || queue_count_o != 3'd0) && n < budget);
    if (busy_o || queue_count_o != 3'd0) begin
      checks++; errors++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 8'd0; flush = 1'b0;
    cpu_done = 1'b0; result_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready",   {31'd0, req_ready_o},      32'd1);
    chk("rst_start",   {31'd0, cpu_start_o},      32'd0);
    chk("rst_saddr",   {24'd0, cpu_start_addr_o}, 32'd0);
    chk("rst_valid",   {31'd0, result_valid_o},   32'd0);
    chk("rst_raddr",   {24'd0, result_addr_o},    32'd0);
    chk("rst_cycles",  {17'd0, result_cycles_o},  32'd0);
    chk("rst_timeout", {31'd0, result_timeout_o}, 32'd0);
    chk("rst_busy",    {31'd0, busy_o},           32'd0);
    chk("rst_count",   {29'd0, queue_count_o},    32'd0);

    // Single run, done on 5th WAIT cycle
    exp_result(8'd139, 5, 1'b0);
    push(8'd139, 1'b1);
    run_done(5);
    wait_idle(100);

    // Stale done masked in first WAIT cycle
    exp_result(8'd50, 3, 1'b0);
    push(8'd50, 1'b1);
    cpu_done = 1'b1;
    wait_start();
    @(posedge clk); #1;
    @(posedge clk); #1 cpu_done = 1'b0;
    @(posedge clk); #1 cpu_done = 1'b1;
    @(posedge clk); #1 cpu_done = 1'b0;
    wait_idle(100);

    // Timeout, then done on the timeout cycle
    exp_result(8'd77, 10, 1'b1);
    push(8'd77, 1'b1);
    wait_idle(100);
    exp_result(8'd78, 10, 1'b0);
    push(8'd78, 1'b1);
    run_done(10);
    wait_idle(100);

    // Queue full while first run sits in WAIT
    exp_result(8'd93, 10, 1'b1);  exp_result(8'd138, 10, 1'b1);
    exp_result(8'd7, 10, 1'b1);   exp_result(8'd200, 10, 1'b1);
    exp_result(8'd11, 10, 1'b1);
    push(8'd93, 1'b1); push(8'd138, 1'b1); push(8'd7, 1'b1);
    push(8'd200, 1'b1); push(8'd11, 1'b1);
    chk("full_ready", {31'd0, req_ready_o},   32'd0);
    chk("full_count", {29'd0, queue_count_o}, 32'd4);
    req_valid = 1'b1; req_addr = 8'd99;
    @(posedge clk); #1 req_valid = 1'b0;
    chk("full_nopush_count", {29'd0, queue_count_o}, 32'd4);
    chk("full_nopush_busy",  {31'd0, busy_o},        32'd1);
    wait_idle(400);

    // Back-pressure with flush of queued work during REPORT
    result_ready = 1'b0;
    exp_result(8'd60, 4, 1'b0);
    push(8'd60, 1'b1);
    run_done(4);
    push(8'd1, 1'b0); push(8'd2, 1'b0); push(8'd3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid",   {31'd0, result_valid_o},   32'd1);
      chk("bp_addr",    {24'd0, result_addr_o},    32'd60);
      chk("bp_cycles",  {17'd0, result_cycles_o},  32'd4);
      chk("bp_timeout", {31'd0, result_timeout_o}, 32'd0);
    end
    chk("bp_count", {29'd0, queue_count_o}, 32'd3);
    flush = 1'b1; req_valid = 1'b1; req_addr = 8'd4;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_count", {29'd0, queue_count_o}, 32'd0);
    chk("flush_valid", {31'd0, result_valid_o}, 32'd1);
    chk("flush_addr",  {24'd0, result_addr_o},  32'd60);
    result_ready = 1'b1;
    wait_idle(50);

    // Reset mid-WAIT with entries still queued
    push(8'd33, 1'b1); push(8'd34, 1'b0); push(8'd35, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_busy",  {31'd0, busy_o},         32'd0);
    chk("mrst_count", {29'd0, queue_count_o},  32'd0);
    chk("mrst_valid", {31'd0, result_valid_o}, 32'd0);
    chk("mrst_ready", {31'd0, req_ready_o},    32'd1);
    chk("mrst_start", {31'd0, cpu_start_o},    32'd0);
    repeat (20) @(negedge clk);
    chk("mrst_idle", {31'd0, busy_o}, 32'd0);

    chk("launch_queue_empty", exp_launch.size(), 32'd0);
    chk("result_queue_empty", exp_res.size(),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
